// File: rtl/data_mem_pkg.sv
// Shared constants for the byte-lane data memory and the execute-stage store decoder.
package data_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    // wren is active low: 0 writes, 1 only reads
    localparam logic WREN_WRITE = 1'b0;
    localparam logic WREN_READ  = 1'b1;

    // Per-lane write enables for a 32-bit word built from four byte lanes
    localparam logic [3:0] WREN_WORD = 4'b0000;
    localparam logic [3:0] WREN_HALF = 4'b1100;
    localparam logic [3:0] WREN_BYTE = 4'b1110;
    localparam logic [3:0] WREN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        STORE_BYTE = 2'd0,
        STORE_HALF = 2'd1,
        STORE_WORD = 2'd2
    } store_size_e;

    function automatic logic [3:0] lane_wren(input store_size_e size, input logic store_en);
        logic [3:0] mask;
        mask = WREN_NONE;
        if (store_en) begin
            unique case (size)
                STORE_BYTE: mask = WREN_BYTE;
                STORE_HALF: mask = WREN_HALF;
                STORE_WORD: mask = WREN_WORD;
                default:    mask = WREN_NONE;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/data_mem.sv
// One byte lane of the data memory: registered address, active-low write, write-through read.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    ADDR_W    = ADDR_W_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic [ADDR_W-1:0] address,
  input  logic              clk,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  input  logic              rst
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      rd_en_q <= 1'b0;
    end else begin
      addr_q  <= address;
      rd_en_q <= 1'b1;
    end
  end

  // No reset on the array so it maps to block RAM; rst only gates the write
  always_ff @(posedge clk) begin
    if (!rst && wren == WREN_WRITE) begin
      mem[address] <= data;
    end
  end

  // Reading through the registered address makes a same-address write visible right after the edge
  assign q = rd_en_q ? mem[addr_q] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Four byte lanes of data_mem forming a 32-bit word, checked against a word-level model.
module tb_data_mem;
    import data_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic [31:0] q;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        data_mem #(.DATA_W(8), .ADDR_W(8)) u_lane (
            .address(address),
            .clk    (clk),
            .data   (data[8*i +: 8]),
            .wren   (wmask[i]),
            .q      (q[8*i +: 8]),
            .rst    (rst)
        );
    end

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    int          checks = 0;
    int          errors = 0;

    // One clock of stimulus: drive on the falling edge, apply the store to the model,
    // and queue the word the memory must show after the next rising edge.
    task automatic cycle(input logic r, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] m, input string tag);
        exp_t e;
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        rst     = r;
        address = a;
        data    = d;
        wmask   = m;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                if (!m[i]) model[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        e.exp = r ? 32'h0 : model[a];
        e.tag = tag;
        sb.push_back(e);
        if (r && !was_rst) begin
            #1;
            checks++;
            if (q !== 32'h0) begin
                errors++;
                $display("FAIL async_reset_clear q=%h expected=00000000", q);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== e.exp) begin
                    errors++;
                    $display("FAIL %s addr=%h q=%h expected=%h", e.tag, address, q, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        logic [3:0] masks [4];
        masks[0] = WREN_WORD;
        masks[1] = WREN_HALF;
        masks[2] = WREN_BYTE;
        masks[3] = WREN_NONE;
        address = '0;
        data    = '0;
        wmask   = WREN_NONE;

        // Writes attempted while reset is held must be ignored and q stays 0
        repeat (3) cycle(1'b1, 8'($urandom), $urandom, WREN_WORD, "reset_hold");

        for (int a = 0; a < 256; a++) cycle(1'b0, 8'(a), $urandom, WREN_WORD, "fill");

        // Contents survive a reset pulse that carries write attempts
        cycle(1'b1, 8'h40, $urandom, WREN_WORD, "reset_pulse");
        cycle(1'b1, 8'h41, $urandom, WREN_WORD, "reset_pulse");
        cycle(1'b0, 8'h40, 32'h0, WREN_NONE, "persist_after_reset");
        cycle(1'b0, 8'h41, 32'h0, WREN_NONE, "persist_after_reset");

        cycle(1'b0, 8'h10, 32'hA5A5_A5A5, WREN_WORD, "write_10");
        cycle(1'b0, 8'hFF, 32'h5A5A_5A5A, WREN_WORD, "write_ff");
        cycle(1'b0, 8'h10, 32'h0, WREN_NONE, "read_10");
        cycle(1'b0, 8'hFF, 32'h0, WREN_NONE, "read_ff");

        repeat (4) cycle(1'b0, 8'h10, 32'h0, WREN_NONE, "read_only_10");

        cycle(1'b0, 8'h20, 32'h3C3C_3C3C, WREN_WORD, "read_during_write");

        cycle(1'b0, 8'h03, 32'h1234_5678, WREN_WORD, "store_word");
        cycle(1'b0, 8'h03, 32'hFFFF_ABCD, WREN_HALF, "store_half");
        cycle(1'b0, 8'h03, 32'h0000_00EE, WREN_BYTE, "store_byte");
        cycle(1'b0, 8'h03, 32'h0, WREN_NONE, "read_mixed_store");

        // Reset lands on the write to 0x02 only
        cycle(1'b0, 8'h00, 32'hC0C0_0000, WREN_WORD, "burst_00");
        cycle(1'b0, 8'h01, 32'hC1C1_1111, WREN_WORD, "burst_01");
        cycle(1'b1, 8'h02, 32'hC2C2_2222, WREN_WORD, "burst_02_reset");
        cycle(1'b0, 8'h03, 32'hC3C3_3333, WREN_WORD, "burst_03");
        for (int a = 0; a < 4; a++) cycle(1'b0, 8'(a), 32'h0, WREN_NONE, "burst_readback");

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 31) == 0), 8'($urandom), $urandom,
                  masks[$urandom_range(0, 3)], "random");
        end

        cycle(1'b0, 8'h00, 32'h0, WREN_NONE, "final_read");
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
